// File: rtl/muldiv_sched_pkg.sv
// Shared types and op-class helpers for the mul/div execute-stage sequencer.
package muldiv_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MADD  = 4'd4,
      OP_MADDU = 4'd5,
      OP_MSUB  = 4'd6,
      OP_MSUBU = 4'd7,
      OP_MUL   = 4'd8
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_HOLD = 2'd3
   } md_state_t;

   function automatic logic is_div(md_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed(md_op_t op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) ||
             (op == OP_MSUB) || (op == OP_MUL);
   endfunction

   function automatic logic writes_hilo(md_op_t op);
      return op != OP_MUL;
   endfunction

   function automatic logic is_acc(md_op_t op);
      return (op == OP_MADD) || (op == OP_MADDU);
   endfunction

   function automatic logic is_sub(md_op_t op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// E-stage, unit and HI/LO signals of the mul/div sequencer; master is the sequencer side.
interface muldiv_sched_if #(parameter int W = 32);
   import muldiv_pkg::*;

   logic           op_valid_i;
   md_op_t         op_i;
   logic [W-1:0]   src_a_i;
   logic [W-1:0]   src_b_i;
   logic [2*W-1:0] hilo_i;
   logic           stall_ext_i;
   logic           flush_i;
   logic           flush_exc_i;
   logic [W-1:0]   op_a_o;
   logic [W-1:0]   op_b_o;
   logic           mul_start_o;
   logic           mul_sign_o;
   logic           mul_ready_i;
   logic [2*W-1:0] mul_result_i;
   logic           div_start_o;
   logic           div_sign_o;
   logic           div_annul_o;
   logic           div_ready_i;
   logic [2*W-1:0] div_result_i;
   logic           stall_o;
   logic           hilo_we_o;
   logic [2*W-1:0] hilo_wdata_o;
   logic [W-1:0]   mul_lo_o;

   modport master (
      input  op_valid_i, op_i, src_a_i, src_b_i, hilo_i, stall_ext_i, flush_i, flush_exc_i,
             mul_ready_i, mul_result_i, div_ready_i, div_result_i,
      output op_a_o, op_b_o, mul_start_o, mul_sign_o, div_start_o, div_sign_o, div_annul_o,
             stall_o, hilo_we_o, hilo_wdata_o, mul_lo_o
   );

   modport slave (
      output op_valid_i, op_i, src_a_i, src_b_i, hilo_i, stall_ext_i, flush_i, flush_exc_i,
             mul_ready_i, mul_result_i, div_ready_i, div_result_i,
      input  op_a_o, op_b_o, mul_start_o, mul_sign_o, div_start_o, div_sign_o, div_annul_o,
             stall_o, hilo_we_o, hilo_wdata_o, mul_lo_o
   );

endinterface

// File: rtl/muldiv_sched.sv
// Launches the shared multiplier/divider for one E-stage op, stalls until the result
// returns, and issues the single HI/LO write as the instruction leaves E.
module muldiv_sched #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_sched_if.master bus
);
   import muldiv_pkg::*;

   md_state_t      state_reg, state_next;
   md_op_t         op_reg, op_next;
   logic [W-1:0]   op_a_reg, op_a_next;
   logic [W-1:0]   op_b_reg, op_b_next;
   logic [2*W-1:0] res_reg, res_next;
   logic           nowrite_reg, nowrite_next;
   logic [2*W-1:0] acc_sum, acc_dif;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         op_reg      <= OP_MULT;
         op_a_reg    <= '0;
         op_b_reg    <= '0;
         res_reg     <= '0;
         nowrite_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         op_a_reg    <= op_a_next;
         op_b_reg    <= op_b_next;
         res_reg     <= res_next;
         nowrite_reg <= nowrite_next;
      end
   end

   // Accumulate source is sampled in the write cycle so an older HI/LO write is seen.
   assign acc_sum = bus.hilo_i + res_reg;
   assign acc_dif = bus.hilo_i - res_reg;

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      op_a_next    = op_a_reg;
      op_b_next    = op_b_reg;
      res_next     = res_reg;
      nowrite_next = nowrite_reg;

      bus.op_a_o       = op_a_reg;
      bus.op_b_o       = op_b_reg;
      bus.mul_lo_o     = res_reg[W-1:0];
      bus.mul_start_o  = 1'b0;
      bus.mul_sign_o   = 1'b0;
      bus.div_start_o  = 1'b0;
      bus.div_sign_o   = 1'b0;
      bus.div_annul_o  = 1'b0;
      bus.stall_o      = 1'b0;
      bus.hilo_we_o    = 1'b0;
      bus.hilo_wdata_o = '0;

      case (state_reg)
         ST_IDLE: begin
            if (bus.op_valid_i && !bus.flush_i) begin
               bus.stall_o  = 1'b1;
               op_next      = bus.op_i;
               op_a_next    = bus.src_a_i;
               op_b_next    = bus.src_b_i;
               nowrite_next = 1'b0;
               // A zero divisor never reaches the divider; HI/LO is left untouched.
               if (is_div(bus.op_i) && (bus.src_b_i == '0)) begin
                  state_next   = ST_HOLD;
                  nowrite_next = 1'b1;
               end else if (is_div(bus.op_i)) begin
                  state_next = ST_DIV;
               end else begin
                  state_next = ST_MUL;
               end
            end
         end
         ST_MUL: begin
            bus.stall_o     = 1'b1;
            bus.mul_sign_o  = is_signed(op_reg);
            bus.mul_start_o = !bus.flush_i;
            if (bus.flush_i) begin
               state_next = ST_IDLE;
            end else if (bus.mul_ready_i) begin
               res_next   = bus.mul_result_i;
               state_next = ST_HOLD;
            end
         end
         ST_DIV: begin
            bus.stall_o     = 1'b1;
            bus.div_sign_o  = is_signed(op_reg);
            bus.div_start_o = !bus.flush_i;
            bus.div_annul_o = bus.flush_i;
            if (bus.flush_i) begin
               state_next = ST_IDLE;
            end else if (bus.div_ready_i) begin
               res_next   = bus.div_result_i;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            bus.hilo_we_o = writes_hilo(op_reg) && !nowrite_reg && !bus.stall_ext_i &&
                            !bus.flush_exc_i && !bus.flush_i;
            if (is_acc(op_reg)) begin
               bus.hilo_wdata_o = acc_sum;
            end else if (is_sub(op_reg)) begin
               bus.hilo_wdata_o = acc_dif;
            end else begin
               bus.hilo_wdata_o = res_reg;
            end
            if (bus.flush_i || !bus.stall_ext_i) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench: the bench plays E stage and both units, and a per-cycle compare
// process checks the sequencer against expectations derived from the op semantics.
module tb_muldiv_sched;
   import muldiv_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic chk_en;

   muldiv_sched_if #(.W(32)) bus ();

   muldiv_sched #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected values for the current cycle, written by the driver after each posedge.
   logic        exp_stall, exp_mstart, exp_msign, exp_dstart, exp_dsign, exp_annul, exp_we;
   logic [63:0] exp_wdata;
   logic        ops_en, lo_en;
   logic [31:0] exp_a, exp_b, exp_lo;
   int          lit_kind;
   logic [63:0] lit_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall_o", 64'(bus.stall_o), 64'(exp_stall));
         chk("mul_start_o", 64'(bus.mul_start_o), 64'(exp_mstart));
         chk("mul_sign_o", 64'(bus.mul_sign_o), 64'(exp_msign));
         chk("div_start_o", 64'(bus.div_start_o), 64'(exp_dstart));
         chk("div_sign_o", 64'(bus.div_sign_o), 64'(exp_dsign));
         chk("div_annul_o", 64'(bus.div_annul_o), 64'(exp_annul));
         chk("hilo_we_o", 64'(bus.hilo_we_o), 64'(exp_we));
         if (exp_we) chk("hilo_wdata_o", bus.hilo_wdata_o, exp_wdata);
         if (ops_en) begin
            chk("op_a_o", 64'(bus.op_a_o), 64'(exp_a));
            chk("op_b_o", 64'(bus.op_b_o), 64'(exp_b));
         end
         if (lo_en) chk("mul_lo_o", 64'(bus.mul_lo_o), 64'(exp_lo));
         if (lit_kind == 1) chk("wdata_literal", bus.hilo_wdata_o, lit_val);
         if (lit_kind == 2) chk("mul_lo_literal", 64'(bus.mul_lo_o), lit_val);
      end
   end

   // Unit behaviour: full-width product, or {remainder, quotient}.
   function automatic logic [63:0] unit_res(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic signed [31:0] q, r;
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      case (op)
         OP_MULTU, OP_MADDU, OP_MSUBU: return {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 0) return 64'd0;
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         OP_DIVU: begin
            if (b == 0) return 64'd0;
            return {a % b, a / b};
         end
         default: return sa * sb;
      endcase
   endfunction

   function automatic logic [63:0] hilo_value(input md_op_t op, input logic [63:0] res, input logic [63:0] hilo);
      case (op)
         OP_MADD, OP_MADDU: return hilo + res;
         OP_MSUB, OP_MSUBU: return hilo - res;
         default:           return res;
      endcase
   endfunction

   task automatic clear_exp();
      exp_stall = 0; exp_mstart = 0; exp_msign = 0; exp_dstart = 0; exp_dsign = 0;
      exp_annul = 0; exp_we = 0; exp_wdata = '0;
      ops_en = 0; lo_en = 0; exp_a = '0; exp_b = '0; exp_lo = '0;
      lit_kind = 0; lit_val = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hilo, input int lat, input int ext, input logic exc,
                         input int lk, input logic [63:0] lv);
      logic [63:0] res;
      logic dv, dz, sg, wr;
      res = unit_res(op, a, b);
      dv  = (op == OP_DIV) || (op == OP_DIVU);
      dz  = dv && (b == 0);
      sg  = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB, OP_MUL};
      wr  = (op != OP_MUL) && !dz && !exc;
      // Accept cycle
      tick(); clear_exp();
      bus.op_valid_i = 1; bus.op_i = op; bus.src_a_i = a; bus.src_b_i = b; bus.hilo_i = hilo;
      exp_stall = 1;
      if (!dz) begin
         for (int j = 1; j <= lat; j++) begin
            tick(); clear_exp();
            bus.op_valid_i = 0; bus.src_a_i = ~a; bus.src_b_i = ~b;
            exp_stall = 1; ops_en = 1; exp_a = a; exp_b = b;
            if (dv) begin exp_dstart = 1; exp_dsign = sg; end
            else    begin exp_mstart = 1; exp_msign = sg; end
            if (j == lat) begin
               if (dv) begin bus.div_ready_i = 1; bus.div_result_i = res; end
               else    begin bus.mul_ready_i = 1; bus.mul_result_i = res; end
            end else begin
               bus.mul_result_i = 64'hDEAD_BEEF_0BAD_F00D;
               bus.div_result_i = 64'hDEAD_BEEF_0BAD_F00D;
            end
         end
      end
      for (int h = 0; h <= ext; h++) begin
         tick(); clear_exp();
         bus.op_valid_i = 0; bus.mul_ready_i = 0; bus.div_ready_i = 0;
         bus.mul_result_i = '0; bus.div_result_i = '0;
         bus.stall_ext_i = (h < ext); bus.flush_exc_i = exc;
         ops_en = 1; exp_a = a; exp_b = b;
         if (h == ext) begin
            exp_we = wr; exp_wdata = hilo_value(op, res, hilo);
            lit_kind = lk; lit_val = lv;
            if (op == OP_MUL) begin lo_en = 1; exp_lo = res[31:0]; end
         end
      end
      tick(); clear_exp();
      bus.stall_ext_i = 0; bus.flush_exc_i = 0;
   endtask

   task automatic run_flush();
      // Flushed op in IDLE is not accepted
      tick(); clear_exp();
      bus.op_valid_i = 1; bus.op_i = OP_MULT; bus.src_a_i = 32'd9; bus.src_b_i = 32'd9;
      bus.flush_i = 1;
      tick(); clear_exp();
      bus.op_valid_i = 0; bus.flush_i = 0;
      // DIVU in flight, flushed in cycle 3
      tick(); clear_exp();
      bus.op_valid_i = 1; bus.op_i = OP_DIVU; bus.src_a_i = 32'd100; bus.src_b_i = 32'd7;
      exp_stall = 1;
      for (int j = 1; j <= 2; j++) begin
         tick(); clear_exp();
         bus.op_valid_i = 0;
         exp_stall = 1; exp_dstart = 1; ops_en = 1; exp_a = 32'd100; exp_b = 32'd7;
      end
      tick(); clear_exp();
      bus.flush_i = 1; exp_stall = 1; exp_annul = 1;
      tick(); clear_exp();
      bus.flush_i = 0; bus.div_ready_i = 1; bus.div_result_i = {32'd2, 32'd14};
      tick(); clear_exp();
      bus.div_ready_i = 0; bus.div_result_i = '0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; chk_en = 0;
      rst = 0;
      bus.op_valid_i = 0; bus.op_i = OP_MULT; bus.src_a_i = '0; bus.src_b_i = '0;
      bus.hilo_i = '0; bus.stall_ext_i = 0; bus.flush_i = 0; bus.flush_exc_i = 0;
      bus.mul_ready_i = 0; bus.mul_result_i = '0; bus.div_ready_i = 0; bus.div_result_i = '0;
      clear_exp();
      tick();
      // Reset state: everything zero
      clear_exp(); ops_en = 1; lo_en = 1; lit_kind = 1; lit_val = '0;
      chk_en = 1;
      tick(); clear_exp();
      rst = 1;

      run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,        64'd0,            4, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(OP_MADDU, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, 2, 0, 0, 1, 64'h2_0000_0000);
      run_op(OP_DIV,   32'd7,         32'd0,        64'd0,            3, 0, 0, 0, 64'd0);
      run_flush();
      run_op(OP_MSUB,  32'd3,         32'hFFFF_FFFC, 64'd100,         3, 3, 0, 1, 64'd112);
      run_op(OP_MULT,  32'd5,         32'd6,        64'd0,            2, 0, 1, 0, 64'd0);
      run_op(OP_MUL,   32'hFFFF_FFFE, 32'd5,        64'd0,            2, 0, 0, 2, 64'h0000_0000_FFFF_FFF6);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'd0,            5, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIVU,  32'hFFFF_FFF9, 32'd2,        64'd0,            1, 1, 0, 1, 64'h0000_0001_7FFF_FFFC);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,           1, 0, 0, 1, 64'hFFFF_FFFE_0000_0001);
      run_op(OP_MSUBU, 32'd1,         32'd1,        64'd0,            1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(OP_MADD,  32'hFFFF_FFFF, 32'd2,        64'd10,           2, 0, 0, 1, 64'd8);

      tick();
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
